// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage rounding, renormalisation and packing of an unrounded float with valid/ready flow control
// Ports:
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   in_valid_i / in_ready_o     input handshake
//   sig_i, expo_i, mant_i       sign, signed exponent, mantissa (hidden bit at MAN_W, carry at MAN_W+1)
//   rema_i, grs_i, rm_i         remainder, guard/round/sticky, rounding mode
//   snan_i .. diff_i            special-case qualifiers
//   out_valid_o / out_ready_i   output handshake
//   result_o, flags_o           packed result and {NV,DZ,OF,UF,NX}
//   flush_i, flags_clr_i        drop in-flight items / clear sticky flags
//   acc_flags_o                 sticky accumulation of emitted flags
module fp_rnd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 sig_i,
    input  logic [EXP_W+2:0]     expo_i,
    input  logic [MAN_W+1:0]     mant_i,
    input  logic [1:0]           rema_i,
    input  logic [2:0]           grs_i,
    input  logic [2:0]           rm_i,
    input  logic                 snan_i,
    input  logic                 qnan_i,
    input  logic                 dbz_i,
    input  logic                 inf_i,
    input  logic                 zero_i,
    input  logic                 diff_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_W+MAN_W:0] result_o,
    output logic [4:0]           flags_o,
    input  logic                 flush_i,
    input  logic                 flags_clr_i,
    output logic [4:0]           acc_flags_o
);
    localparam int RW = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 3;
    localparam int MW = MAN_W + 2;
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 2);

    typedef struct packed {
        logic          sig;
        logic [XW-1:0] expo;
        logic [MW-1:0] mant;
        logic          rnddn;
        logic          uf;
        logic          nx;
        logic [4:0]    spec;
    } s1_t;

    s1_t           s1_d, s1_q;
    logic          s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic [RW-1:0] result_d, result_q, res;
    logic [4:0]    flags_d, flags_q, flg, acc_d, acc_q;
    logic          s2_en, accept;
    logic          nx, odd, rndup, rnddn, sig_r, sub_up, uf;
    logic [MW-1:0] mant_inc;
    logic          carry;
    logic signed [XW-1:0] expo_n;
    logic [MAN_W-1:0] frac;

    assign s2_en       = ~s2_valid_q | out_ready_i;
    assign in_ready_o  = ~s1_valid_q | s2_en;
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = s2_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign acc_flags_o = acc_q;

    assign nx  = (rema_i != 2'd0) | (grs_i != 3'd0);
    assign odd = mant_i[0] | grs_i[1] | grs_i[0] | (rema_i == 2'd1);

    // Directed modes only adjust away from zero for the matching sign; RDN turns an exact x-x into -0.
    always_comb begin
        rndup = 1'b0;
        rnddn = 1'b0;
        sig_r = sig_i;
        case (rm_i)
            3'd0: rndup = grs_i[2] & odd;
            3'd1: rnddn = 1'b1;
            3'd2: begin
                if (sig_i & nx) rndup = 1'b1;
                else if (~sig_i & zero_i & diff_i) sig_r = 1'b1;
                else if (~sig_i) rnddn = 1'b1;
            end
            3'd3: begin
                if (~sig_i & nx) rndup = 1'b1;
                else if (sig_i) rnddn = 1'b1;
            end
            3'd4: rndup = grs_i[2] & nx;
            default: ;
        endcase
    end

    assign mant_inc = mant_i + {{(MW-1){1'b0}}, rndup};
    // A subnormal rounding into the hidden bit becomes the smallest normal; tininess is judged before rounding
    // except when the discarded bits alone already carried it over.
    assign sub_up = (expo_i == '0) & rndup & mant_inc[MAN_W];
    assign uf = (expo_i == '0) &
                (sub_up ? ~(grs_i[2] & grs_i[1]) & ~((grs_i == 3'd5) & ((rm_i == 3'd2) | (rm_i == 3'd3))) : nx);

    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            s1_d.sig   = sig_r;
            s1_d.expo  = sub_up ? XW'(1) : expo_i;
            s1_d.mant  = mant_inc;
            s1_d.rnddn = rnddn;
            s1_d.uf    = uf;
            s1_d.nx    = nx;
            s1_d.spec  = {snan_i, qnan_i, dbz_i, inf_i, zero_i};
        end
    end

    assign carry  = s1_q.mant[MW-1];
    assign expo_n = s1_q.expo + XW'(carry);
    assign frac   = carry ? s1_q.mant[MAN_W:1] : s1_q.mant[MAN_W-1:0];

    always_comb begin
        res = {s1_q.sig, expo_n[EXP_W-1:0], frac};
        flg = {3'b000, s1_q.uf, s1_q.nx};
        if (s1_q.spec[4]) begin
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flg = 5'b10000;
        end else if (s1_q.spec[3]) begin
            res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flg = 5'b00000;
        end else if (s1_q.spec[2]) begin
            res = {s1_q.sig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 5'b01000;
        end else if (s1_q.spec[1]) begin
            res = {s1_q.sig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 5'b00000;
        end else if (s1_q.spec[0]) begin
            res = {s1_q.sig, {(RW-1){1'b0}}};
            flg = 5'b00000;
        end else if (s1_q.rnddn & (expo_n > EMAX)) begin
            // Rounding toward zero saturates to the largest finite value instead of infinity.
            res = {s1_q.sig, EMAX[EXP_W-1:0], {MAN_W{1'b1}}};
            flg = 5'b00101;
        end else if (expo_n > EMAX) begin
            res = {s1_q.sig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 5'b00101;
        end
    end

    assign s1_valid_d = flush_i ? 1'b0 : (in_ready_o ? in_valid_i : s1_valid_q);
    assign s2_valid_d = flush_i ? 1'b0 : (s2_en ? s1_valid_q : s2_valid_q);
    assign result_d   = (s2_en & s1_valid_q) ? res : result_q;
    assign flags_d    = (s2_en & s1_valid_q) ? flg : flags_q;
    assign acc_d      = (flags_clr_i ? 5'd0 : acc_q) | ((s2_valid_q & out_ready_i) ? flags_q : 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            acc_q      <= acc_d;
        end
    end
endmodule

// File: doc/fp_rnd_pipe.md
FP_RND_PIPE -- requirements
Module: fp_rnd_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; result width RW = 1+EXP_W+MAN_W.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have in_valid in 1, in_ready out 1: input handshake.
REQ-006 SHALL have sig in 1; expo in EXP_W+3; mant in MAN_W+2 (hidden bit at MAN_W, carry at MAN_W+1); rema in 2; grs in 3; rm in 3.
REQ-007 SHALL have snan, qnan, dbz, inf, zero, diff, each in 1: special-case qualifiers.
REQ-008 SHALL have out_valid out 1, out_ready in 1: output handshake.
REQ-009 SHALL have result out RW and flags out 5, bits {NV,DZ,OF,UF,NX} = [4:0].
REQ-010 SHALL have flush in 1, flags_clr in 1, and acc_flags out 5, sticky accumulated flags.

Function
REQ-011 SHALL be a 2-stage pipeline: S1 computes the rounding decision and increment; S2 renormalises, classifies specials and packs; latency 2 cycles from accept to out_valid.
REQ-012 SHALL accept on in_valid&in_ready and emit on out_valid&out_ready, with order preserved.
REQ-013 SHALL drive in_ready = ~s1_valid | (~s2_valid | out_ready), S1 advancing only when ~s2_valid|out_ready, so back-to-back throughput is 1 per cycle with no bubble and no loss under backpressure.
REQ-014 SHALL hold result and flags stable while out_valid&~out_ready.
REQ-015 SHALL compute NX = (rema!=0)|(grs!=0) and odd = mant[0]|grs[1]|grs[0]|(rema==1).
REQ-016 SHALL round per rm: 0 RNE rndup=grs[2]&odd; 1 RTZ rnddn; 2 RDN: sig&NX rndup, else ~sig&zero&diff forces sig=1, else ~sig rnddn; 3 RUP: ~sig&NX rndup, else sig rnddn; 4 RMM rndup=grs[2]&NX; 5-7 no rounding.
REQ-017 SHALL set UF=NX when expo==0.
REQ-018 SHALL handle a subnormal that rounds up with a set bit MAN_W: expo becomes 1, UF=0 for grs 6/7, UF=0 for grs 5 with rm 2/3, otherwise UF=1.
REQ-019 SHALL clamp on rnddn with expo >= 2^EXP_W-1: expo = 2^EXP_W-2, fraction all ones, flags=00101.
REQ-020 SHALL renormalise when mant[MAN_W+1]=1 after increment: expo+1, mant>>1.
REQ-021 SHALL output, for a non-special with signed expo > 2^EXP_W-2: {sig, all-ones, 0}, flags=00101.
REQ-022 SHALL apply specials in priority snan > qnan > dbz > inf > zero.
REQ-023 SHALL encode NaN as {0, all-ones, MSB-only fraction}; dbz/inf as {sig, all-ones, 0}; zero as {sig, 0, 0}.
REQ-024 SHALL force flags per special: snan 10000; qnan/inf/zero 00000; dbz 01000.
REQ-025 SHALL output expo==0 non-specials as {sig, 0, mant[MAN_W-1:0]}; otherwise {sig, expo[EXP_W-1:0], mant[MAN_W-1:0]}.
REQ-026 SHALL update acc_flags each cycle as acc_flags = (flags_clr ? 0 : acc_flags) | (out_valid&out_ready ? flags : 0).
REQ-027 SHALL clear both stage valids on flush at the next edge, leave acc_flags unchanged, and let flush override a simultaneous accept.

Reset
REQ-028 SHALL, with reset low, asynchronously clear s1_valid, s2_valid, out_valid, result, flags, and acc_flags to 0, with in_ready=1 after reset.
REQ-029 SHALL, on reset asserted mid-operation, discard all in-flight items with no output handshake.

Verification (EXP_W=8, MAN_W=23)
REQ-030 SHALL cover: expo=127, mant=0x0800001, grs=100, rm=0 -> result 0x3F800002, flags 00001, 2 cycles later.
REQ-031 SHALL cover: expo=254, mant=0x0FFFFFF, grs=110, rm=0 -> 0x7F800000, flags 00101.
REQ-032 SHALL cover: expo=255, rm=1, sig=0 -> 0x7F7FFFFF, flags 00101; snan=1 -> 0x7FC00000, flags 10000.
REQ-033 SHALL cover: 4 consecutive inputs with out_ready=0 for 3 cycles -> in_ready low after 2 accepts, all 4 emitted in order, none duplicated.
REQ-034 SHALL cover: outputs with flags 00001 then 10000 -> acc_flags=10001; flags_clr on a handshake of 00101 -> acc_flags=00101.
REQ-035 SHALL cover: reset low with both stages full -> out_valid=0 immediately; after release no stale output appears.
